// File: rtl/uart_pkg.sv
// uart_pkg: UART types and constants shared by the RX and TX paths
package uart_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD = 1'b1;
   localparam int MIN_PRESCALE = 4;
endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit edge/bit counters and 3-sample majority voter
module uart_rx_sampler #(
   parameter int PRESCALE_W = 6,
   parameter int IDX_W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  rx,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic                  bit_done,
   output logic                  bit_val,
   output logic                  bit_end,
   output logic [IDX_W-1:0]      bit_idx
);
   localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);
   logic [PRESCALE_W-1:0] cnt_q, cnt_d, half;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [1:0] smp_q, smp_d;
   always_comb begin
      half = prescale >> 1;
      bit_end = cnt_q == prescale - ONE;
      bit_done = cnt_q == half + ONE;
      // third vote is the live line value at the decision edge
      bit_val = (smp_q[0] & smp_q[1]) | (rx & (smp_q[0] | smp_q[1]));
      bit_idx = idx_q;
      cnt_d = (clr || bit_end) ? '0 : cnt_q + ONE;
      idx_d = clr ? '0 : idx_q + IDX_W'(bit_end);
      smp_d = smp_q;
      if (cnt_q == half - ONE) smp_d[0] = rx;
      if (cnt_q == half) smp_d[1] = rx;
   end
   always_ff @(posedge clk)
      if (rst) begin
         cnt_q <= '0;
         idx_q <= '0;
         smp_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         smp_q <= smp_d;
      end
endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: UART receiver with runtime parity/stop config, majority voting,
// start-glitch rejection and separate parity/framing error pulses
module uart_rx_cfg #(
   parameter int DATA_W = 8,
   parameter int PRESCALE_W = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  RX_IN,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  STOP2,
   input  logic [PRESCALE_W-1:0] Prescale,
   output logic [DATA_W-1:0]     P_DATA,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err,
   output logic                  busy
);
   import uart_pkg::*;
   localparam int IDX_W = 4;
   localparam logic [PRESCALE_W-1:0] P_MIN = PRESCALE_W'(MIN_PRESCALE);
   rx_state_t state_q, state_d;
   logic [PRESCALE_W-1:0] p_q, p_d;
   logic par_en_q, par_en_d, par_typ_q, par_typ_d, stop2_q, stop2_d;
   logic [DATA_W-1:0] sh_q, sh_d, pdata_q, pdata_d;
   logic par_q, par_d, stp_ok_q, stp_ok_d;
   logic dv_q, dv_d, pe_q, pe_d, se_q, se_d;
   logic bit_done, bit_val, bit_end, par_exp, perr, serr;
   logic [IDX_W-1:0] bit_idx, last_idx;

   uart_rx_sampler #(.PRESCALE_W(PRESCALE_W), .IDX_W(IDX_W)) u_smp (
      .clk(clk),
      .rst(rst),
      .clr(state_d == IDLE),
      .rx(RX_IN),
      .prescale(p_q),
      .bit_done(bit_done),
      .bit_val(bit_val),
      .bit_end(bit_end),
      .bit_idx(bit_idx)
   );

   always_comb begin
      state_d = state_q;
      p_d = p_q;
      par_en_d = par_en_q;
      par_typ_d = par_typ_q;
      stop2_d = stop2_q;
      sh_d = sh_q;
      par_d = par_q;
      stp_ok_d = stp_ok_q;
      pdata_d = pdata_q;
      dv_d = 1'b0;
      pe_d = 1'b0;
      se_d = 1'b0;
      last_idx = IDX_W'(DATA_W + 1) + IDX_W'(par_en_q) + IDX_W'(stop2_q);
      par_exp = (par_typ_q == PAR_EVEN) ? 1'b0 : 1'b1;
      perr = par_en_q & (par_q != par_exp);
      serr = ~(stp_ok_q & bit_val);
      case (state_q)
         IDLE: if (!RX_IN) begin
            state_d = START;
            p_d = (Prescale < P_MIN) ? P_MIN : Prescale;
            par_en_d = PAR_EN;
            par_typ_d = PAR_TYP;
            stop2_d = STOP2;
            par_d = 1'b0;
            stp_ok_d = 1'b1;
         end
         START: state_d = (bit_done && bit_val) ? IDLE : bit_end ? DATA : START;
         DATA: begin
            if (bit_done) begin
               sh_d = {bit_val, sh_q[DATA_W-1:1]};
               par_d = par_q ^ bit_val;
            end
            if (bit_end && bit_idx == IDX_W'(DATA_W)) state_d = par_en_q ? PARITY : STOP;
         end
         PARITY: begin
            if (bit_done) par_d = par_q ^ bit_val;
            if (bit_end) state_d = STOP;
         end
         STOP: if (bit_done) begin
            stp_ok_d = stp_ok_q & bit_val;
            // finish at the last stop bit's decision edge to resync early
            if (bit_idx == last_idx) begin
               state_d = IDLE;
               dv_d = ~perr & ~serr;
               pe_d = perr;
               se_d = serr;
               pdata_d = dv_d ? sh_q : pdata_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk)
      if (rst) begin
         state_q <= IDLE;
         p_q <= P_MIN;
         par_en_q <= 1'b0;
         par_typ_q <= 1'b0;
         stop2_q <= 1'b0;
         sh_q <= '0;
         par_q <= 1'b0;
         stp_ok_q <= 1'b0;
         pdata_q <= '0;
         dv_q <= 1'b0;
         pe_q <= 1'b0;
         se_q <= 1'b0;
      end else begin
         state_q <= state_d;
         p_q <= p_d;
         par_en_q <= par_en_d;
         par_typ_q <= par_typ_d;
         stop2_q <= stop2_d;
         sh_q <= sh_d;
         par_q <= par_d;
         stp_ok_q <= stp_ok_d;
         pdata_q <= pdata_d;
         dv_q <= dv_d;
         pe_q <= pe_d;
         se_q <= se_d;
      end

   assign P_DATA = pdata_q;
   assign data_valid = dv_q;
   assign par_err = pe_q;
   assign stp_err = se_q;
   assign busy = state_q != IDLE;
endmodule
